// File: rtl/sobel_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sobel_frame_ctrl
// Purpose  : Frame sequencer around a streaming conv2d (Sobel) core. Passes
//            one frame of grayscale pixels into the core, then pushes
//            LINE_W_P+1 zero beats to drain the line buffers. It discards the
//            core's warm-up results and forwards the remaining results
//            downstream, tagged with their (column, row) position.
// Ports    : clk_i, rst_i           clock, synchronous active-high reset
//            start_i/busy_o/done_o  frame control and status
//            pix_*                  upstream pixel stream (valid/ready)
//            cv_*                   feed stream into the conv2d core
//            res_*                  magnitude stream from the conv2d core
//            out_*                  downstream result stream, out_col_o and
//                                   out_row_o give the current output position
// Config   : SOBEL_BORDER_ZERO_EN   when defined, forces output data to zero
//                                   on the outermost rows and columns
// Revision : 1.0  initial release
// ============================================================================
module sobel_frame_ctrl #(
  parameter int WIDTH_P   = 8,
  parameter int LINE_W_P  = 640,
  parameter int FRAME_H_P = 480
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  input  logic [WIDTH_P-1:0]           pix_data_i,
  input  logic                         pix_valid_i,
  output logic                         pix_ready_o,
  output logic [WIDTH_P-1:0]           cv_data_o,
  output logic                         cv_valid_o,
  input  logic                         cv_ready_i,
  input  logic [WIDTH_P-1:0]           res_data_i,
  input  logic                         res_valid_i,
  output logic                         res_ready_o,
  output logic [WIDTH_P-1:0]           out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [$clog2(LINE_W_P)-1:0]  out_col_o,
  output logic [$clog2(FRAME_H_P)-1:0] out_row_o
);

  localparam int N_LP     = LINE_W_P * FRAME_H_P;
  localparam int W_LP     = LINE_W_P + 1;
  localparam int IC_W_LP  = $clog2(N_LP + 1);
  localparam int FC_W_LP  = $clog2(W_LP + 1);
  localparam int COL_W_LP = $clog2(LINE_W_P);
  localparam int ROW_W_LP = $clog2(FRAME_H_P);

  localparam logic [IC_W_LP-1:0]  N_LAST_LP   = IC_W_LP'(N_LP - 1);
  localparam logic [FC_W_LP-1:0]  W_LAST_LP   = FC_W_LP'(W_LP - 1);
  localparam logic [FC_W_LP-1:0]  W_CNT_LP    = FC_W_LP'(W_LP);
  localparam logic [COL_W_LP-1:0] COL_LAST_LP = COL_W_LP'(LINE_W_P - 1);
  localparam logic [ROW_W_LP-1:0] ROW_LAST_LP = ROW_W_LP'(FRAME_H_P - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  state_e               state_q,    state_d;
  logic [IC_W_LP-1:0]   in_cnt_q,   in_cnt_d;
  logic [IC_W_LP-1:0]   out_cnt_q,  out_cnt_d;
  logic [FC_W_LP-1:0]   fl_cnt_q,   fl_cnt_d;
  logic [FC_W_LP-1:0]   warm_cnt_q, warm_cnt_d;
  logic [COL_W_LP-1:0]  col_q,      col_d;
  logic [ROW_W_LP-1:0]  row_q,      row_d;
  logic                 done_q,     done_d;

  logic busy_w, warm_w, cv_fire_w, res_fire_w, out_fire_w, out_last_w;

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    fl_cnt_d    = fl_cnt_q;
    warm_cnt_d  = warm_cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    done_d      = 1'b0;
    pix_ready_o = 1'b0;
    cv_valid_o  = 1'b0;
    cv_data_o   = '0;
    res_ready_o = 1'b1;
    out_valid_o = 1'b0;

    busy_w = (state_q != ST_IDLE);
    // The first W results of a frame are centred on pixels before the frame
    // start; they are swallowed here regardless of downstream readiness.
    warm_w = busy_w && (warm_cnt_q != W_CNT_LP);

    if (busy_w && !warm_w) begin
      out_valid_o = res_valid_i;
      res_ready_o = out_ready_i;
    end

    unique case (state_q)
      ST_FEED: begin
        cv_valid_o  = pix_valid_i;
        pix_ready_o = cv_ready_i;
        cv_data_o   = pix_data_i;
      end
      ST_FLUSH: cv_valid_o = 1'b1;
      default: ;
    endcase

    cv_fire_w  = cv_valid_o && cv_ready_i;
    res_fire_w = res_valid_i && res_ready_o;
    out_fire_w = out_valid_o && out_ready_i;
    out_last_w = out_fire_w && (out_cnt_q == N_LAST_LP);

    if (warm_w && res_fire_w) warm_cnt_d = warm_cnt_q + 1'b1;

    if (out_fire_w) begin
      out_cnt_d = out_cnt_q + 1'b1;
      if (col_q == COL_LAST_LP) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST_LP) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    done_d = out_last_w;

    unique case (state_q)
      ST_IDLE: begin
        // done_q marks the first IDLE cycle after a frame; a start there is
        // deliberately ignored.
        if (start_i && !done_q) begin
          state_d    = ST_FEED;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
          fl_cnt_d   = '0;
          warm_cnt_d = '0;
          col_d      = '0;
          row_d      = '0;
        end
      end
      ST_FEED: begin
        if (cv_fire_w) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == N_LAST_LP) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (cv_fire_w) begin
          fl_cnt_d = fl_cnt_q + 1'b1;
          // A zero-latency core can deliver the final result on the same
          // edge as the final flush beat; skip WAIT in that case.
          if (fl_cnt_q == W_LAST_LP) state_d = out_last_w ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (out_last_w) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      fl_cnt_q   <= '0;
      warm_cnt_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      fl_cnt_q   <= fl_cnt_d;
      warm_cnt_q <= warm_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      done_q     <= done_d;
    end
  end

  assign busy_o    = busy_w;
  assign done_o    = done_q;
  assign out_col_o = col_q;
  assign out_row_o = row_q;

`ifdef SOBEL_BORDER_ZERO_EN
  logic border_w;
  assign border_w   = (row_q == '0) || (row_q == ROW_LAST_LP) ||
                      (col_q == '0) || (col_q == COL_LAST_LP);
  assign out_data_o = border_w ? '0 : res_data_i;
`else
  assign out_data_o = res_data_i;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sobel_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_frame_ctrl
// Purpose  : Self-checking bench for sobel_frame_ctrl with a 4x3 frame.
//            A small conv2d model emits one result per accepted feed beat:
//            the first five are warm-up filler (0xEE), the rest echo the
//            feed delayed by five beats (0xFF everywhere in the border build).
// Revision : 1.0  initial release
// ============================================================================
module tb_sobel_frame_ctrl;

  localparam int WD   = 8;
  localparam int LW   = 4;
  localparam int FH   = 3;
  localparam int NPIX = LW * FH;
  localparam int WARM = LW + 1;
`ifdef SOBEL_BORDER_ZERO_EN
  localparam bit BZ = 1'b1;
`else
  localparam bit BZ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          busy_o, done_o;
  logic [WD-1:0] pix_data_i = '0;
  logic          pix_valid_i = 1'b0;
  logic          pix_ready_o;
  logic [WD-1:0] cv_data_o;
  logic          cv_valid_o;
  logic          cv_ready_i = 1'b0;
  logic [WD-1:0] res_data_i = '0;
  logic          res_valid_i = 1'b0;
  logic          res_ready_o;
  logic [WD-1:0] out_data_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [1:0]    out_col_o;
  logic [1:0]    out_row_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sobel_frame_ctrl #(.WIDTH_P(WD), .LINE_W_P(LW), .FRAME_H_P(FH)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .pix_data_i(pix_data_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .cv_data_o(cv_data_o), .cv_valid_o(cv_valid_o), .cv_ready_i(cv_ready_i),
    .res_data_i(res_data_i), .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_col_o(out_col_o), .out_row_o(out_row_o)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    start_i = 1'b0; pix_valid_i = 1'b0; cv_ready_i = 1'b0;
    res_valid_i = 1'b0; out_ready_i = 1'b0;
  endtask

  typedef struct {
    bit          feed;
    bit          pv;
    bit          cr;
    logic [7:0]  pd;
    bit          rv;
    bit          ordy;
    bit          e_pr;
    bit          e_cv;
    logic [7:0]  e_cd;
    bit          e_rr;
    bit          e_ov;
  } vec_t;

  vec_t vecs [6];

  // One frame with the conv model in the loop. ps/cs/os are stall
  // percentages; poke drives start_i in FEED, WAIT and the done cycle;
  // abort_at >= 0 asserts reset once that many pixels have been accepted.
  task automatic run_frame(input int ps, input int cs, input int os, input bit poke,
                           input int abort_at, input bit do_start);
    int         pix_n = 0, cv_n = 0, res_n = 0, out_n = 0, cyc = 0;
    logic [7:0] hist [0:31];
    bit         last_prev = 1'b0, fin = 1'b0, pf, cf, rf, of;
    logic [7:0] exp_d;
    while (!fin) begin
      @(negedge clk);
      start_i = (do_start && cyc == 0) ||
                (poke && (cyc == 3 || (cv_n == NPIX + WARM && out_n < NPIX) || last_prev));
      rst_i = (abort_at >= 0) && (pix_n == abort_at);
      pix_valid_i = (pix_n < NPIX) && !rst_i && (int'($urandom_range(99)) >= ps);
      pix_data_i  = 8'(pix_n + 1);
      cv_ready_i  = int'($urandom_range(99)) >= cs;
      res_valid_i = (res_n < cv_n) && (int'($urandom_range(99)) >= cs);
      if (BZ)               res_data_i = 8'hFF;
      else if (res_n < WARM) res_data_i = 8'hEE;
      else                  res_data_i = hist[res_n - WARM];
      out_ready_i = int'($urandom_range(99)) >= os;
      #1;
      if (rst_i) begin
        idle_inputs();
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        check("abort_pos", 32'({out_row_o, out_col_o}), 32'd0);
        check("abort_ready", 32'({pix_ready_o, cv_valid_o, res_ready_o}), 32'b001);
        repeat (4) begin
          @(negedge clk); #1;
          check("abort_no_done", 32'(done_o), 32'd0);
        end
        return;
      end
      pf = pix_valid_i && pix_ready_o;
      cf = cv_valid_o && cv_ready_i;
      rf = res_valid_i && res_ready_o;
      of = out_valid_o && out_ready_i;
      check("done_o", 32'(done_o), 32'(last_prev));
      if (last_prev) begin
        check("idle_at_done", 32'(busy_o), 32'd0);
        fin = 1'b1;
      end
      if (cf) check("cv_data", 32'(cv_data_o), (cv_n < NPIX) ? 32'(cv_n + 1) : 32'd0);
      if (pf) check("pix_to_cv", 32'(cf), 32'd1);
      if (rf || of) check("warmup_gate", 32'(of), 32'(rf && (res_n >= WARM)));
      if (of) begin
        if (BZ) exp_d = ((out_n / LW == 1) && (out_n % LW == 1 || out_n % LW == 2)) ? 8'hFF : 8'h00;
        else    exp_d = 8'(out_n + 1);
        check("out_data", 32'(out_data_o), 32'(exp_d));
        check("out_col", 32'(out_col_o), 32'(out_n % LW));
        check("out_row", 32'(out_row_o), 32'(out_n / LW));
      end
      @(posedge clk);
      if (pf) pix_n++;
      if (cf) begin
        hist[cv_n] = (cv_n < NPIX) ? 8'(cv_n + 1) : 8'h00;
        cv_n++;
      end
      if (rf) res_n++;
      if (of) out_n++;
      last_prev = of && (out_n == NPIX);
      cyc++;
      if (cyc > 1000) begin
        total++; bad++;
        $display("FAIL frame_timeout: outputs=%0d expected %0d", out_n, NPIX);
        idle_inputs();
        @(negedge clk); rst_i = 1'b1;
        @(negedge clk); rst_i = 1'b0;
        return;
      end
    end
    check("pix_count", 32'(pix_n), 32'(NPIX));
    check("feed_count", 32'(cv_n), 32'(NPIX + WARM));
    check("out_count", 32'(out_n), 32'(NPIX));
    @(negedge clk);
    idle_inputs();
    #1;
    check("start_in_done_ignored", 32'(busy_o), 32'd0);
    check("idle_after_frame", 32'({pix_ready_o, cv_valid_o, out_valid_o, done_o}), 32'd0);
  endtask

  initial begin
    bit in_feed = 1'b0;
    //          feed pv cr pd     rv or   pr cv cd     rr ov
    vecs[0] = '{1'b0,1'b1,1'b1,8'h5A,1'b1,1'b0, 1'b0,1'b0,8'h00,1'b1,1'b0};
    vecs[1] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1, 1'b0,1'b0,8'h00,1'b1,1'b0};
    vecs[2] = '{1'b1,1'b1,1'b1,8'hA5,1'b0,1'b0, 1'b1,1'b1,8'hA5,1'b1,1'b0};
    vecs[3] = '{1'b1,1'b0,1'b1,8'h11,1'b0,1'b1, 1'b1,1'b0,8'h00,1'b1,1'b0};
    vecs[4] = '{1'b1,1'b1,1'b0,8'h3C,1'b0,1'b1, 1'b0,1'b1,8'h3C,1'b1,1'b0};
    vecs[5] = '{1'b1,1'b0,1'b0,8'h77,1'b0,1'b0, 1'b0,1'b0,8'h00,1'b1,1'b0};

    // Reset, then idle with all inputs low.
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    repeat (8) begin
      @(negedge clk); #1;
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_handshake", 32'({pix_ready_o, cv_valid_o, res_ready_o, out_valid_o}), 32'b0010);
      check("rst_pos", 32'({out_row_o, out_col_o}), 32'd0);
    end

    // Combinational handshake vectors in IDLE, then in FEED before any data.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].feed && !in_feed) begin
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0; in_feed = 1'b1;
      end
      @(negedge clk);
      pix_valid_i = vecs[i].pv; cv_ready_i = vecs[i].cr; pix_data_i = vecs[i].pd;
      res_valid_i = vecs[i].rv; out_ready_i = vecs[i].ordy; res_data_i = 8'h33;
      #1;
      check("vec_handshake", 32'({pix_ready_o, cv_valid_o, res_ready_o, out_valid_o}),
            32'({vecs[i].e_pr, vecs[i].e_cv, vecs[i].e_rr, vecs[i].e_ov}));
      check("vec_busy", 32'(busy_o), 32'(vecs[i].feed));
      if (vecs[i].e_cv) check("vec_cv_data", 32'(cv_data_o), 32'(vecs[i].e_cd));
      #2;
      idle_inputs();
    end

    run_frame(0, 0, 0, 1'b0, -1, 1'b0);    // already in FEED, no stalls
    run_frame(30, 30, 30, 1'b0, -1, 1'b1); // random stalls everywhere
    run_frame(20, 20, 20, 1'b1, -1, 1'b1); // start_i in FEED, WAIT, done cycle
    run_frame(0, 0, 0, 1'b0, 6, 1'b1);     // reset after six pixels
    run_frame(10, 10, 10, 1'b0, -1, 1'b1); // clean frame after the abort

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
